// File: rtl/div_sequencer_if.sv
// Handshake/bus bundle between the execute stage (master) and the
// multi-cycle divide/remainder sequencer (slave).
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [5:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider controller for DIV/DIVU/REM/REMU: one quotient
// bit per cycle on operand magnitudes, sign fix-up when the result is registered.
module div_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] DIV0_RESULT = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    div_sequencer_if.slave   bus
);

    localparam int         CNT_W   = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [5:0] OP_DIV  = 6'b001010;
    localparam logic [5:0] OP_DIVU = 6'b001011;
    localparam logic [5:0] OP_REM  = 6'b001100;
    localparam logic [5:0] OP_REMU = 6'b001101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              op_valid_s;
    logic              op_signed_s;
    logic              op_rem_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN:0]     rem_shift_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   quo_next_s;
    logic [XLEN-1:0]   rem_next_s;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Decode the op code into valid/signed/remainder flags
    always_comb begin
        op_valid_s  = 1'b0;
        op_signed_s = 1'b0;
        op_rem_s    = 1'b0;
        case (bus.op)
            OP_DIV:  begin op_valid_s = 1'b1; op_signed_s = 1'b1; end
            OP_DIVU: begin op_valid_s = 1'b1; end
            OP_REM:  begin op_valid_s = 1'b1; op_signed_s = 1'b1; op_rem_s = 1'b1; end
            OP_REMU: begin op_valid_s = 1'b1; op_rem_s = 1'b1; end
            default: begin op_valid_s = 1'b0; end
        endcase
    end

    // Operand magnitudes and one restoring-division step; the extra MSB of
    // the trial difference is the borrow that decides whether to restore
    always_comb begin
        a_mag_s     = (op_signed_s && bus.a[XLEN-1]) ? negate(bus.a) : bus.a;
        b_mag_s     = (op_signed_s && bus.b[XLEN-1]) ? negate(bus.b) : bus.b;
        rem_shift_s = {rem_q, quo_q[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, dvsr_q};
        if (!diff_s[XLEN]) begin
            rem_next_s = diff_s[XLEN-1:0];
            quo_next_s = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[XLEN-1:0];
            quo_next_s = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Next-state logic for the controller and datapath registers
    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && op_valid_s && !bus.flush) begin
                    is_rem_d  = op_rem_s;
                    neg_quo_d = op_signed_s & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                    neg_rem_d = op_signed_s & bus.a[XLEN-1];
                    quo_d     = a_mag_s;
                    dvsr_d    = b_mag_s;
                    rem_d     = {XLEN{1'b0}};
                    cnt_d     = CNT_W'(XLEN - 1);
                    if (bus.b == {XLEN{1'b0}}) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = DIV0_RESULT;
                    end else begin
                        state_d  = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = quo_next_s;
                    rem_d = rem_next_s;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        if (is_rem_q) begin
                            result_d = neg_rem_q ? negate(rem_next_s) : rem_next_s;
                        end else begin
                            result_d = neg_quo_q ? negate(quo_next_s) : quo_next_s;
                        end
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= {XLEN{1'b0}};
            rem_q     <= {XLEN{1'b0}};
            dvsr_q    <= {XLEN{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            done_q    <= 1'b0;
            result_q  <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.stall  = ((state_q == S_IDLE) && bus.start && op_valid_s) || (state_q == S_RUN);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_div_sequencer;
    localparam int XLEN = 32;
    localparam logic [5:0] OP_DIV  = 6'b001010;
    localparam logic [5:0] OP_DIVU = 6'b001011;
    localparam logic [5:0] OP_REM  = 6'b001100;
    localparam logic [5:0] OP_REMU = 6'b001101;

    logic clk = 1'b0;
    logic rst_n;
    int   check_cnt = 0;
    int   err_cnt   = 0;
    logic [31:0] last_res;

    div_sequencer_if #(.XLEN(XLEN)) bus();

    div_sequencer #(.XLEN(XLEN), .DIV0_RESULT(32'h8000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic with the architectural corner cases
    function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return 32'h8000_0000;
        case (op)
            OP_DIVU: return a / b;
            OP_REMU: return a % b;
            OP_DIV:  if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                     else return 32'(sa / sb);
            OP_REM:  if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                     else return 32'(sa % sb);
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold_start);
        int n;
        int stall_miss;
        int exp_lat;
        logic [31:0] exp_res;
        exp_res    = model(op, a, b);
        exp_lat    = (b == 32'd0) ? 0 : XLEN;
        stall_miss = 0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        #1;
        chk({tag, " stall_req"}, 32'(bus.stall), 32'd1);
        tick();
        if (hold_start) begin
            bus.a = ~a;
            bus.b = b ^ 32'h5;
        end else begin
            bus.start = 1'b0;
        end
        n = 0;
        while (!bus.done && n < 40) begin
            if (!bus.stall) stall_miss++;
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " run_stall"}, 32'(stall_miss), 32'd0);
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " result"}, bus.result, exp_res);
        chk({tag, " done_stall"}, 32'(bus.stall), 32'd0);
        tick();
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " idle"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        tick();
        chk({tag, " no_reaccept"}, 32'(bus.busy), 32'd0);
        chk({tag, " result_hold"}, bus.result, exp_res);
        last_res = exp_res;
    endtask

    initial begin
        int dones;
        int activity;
        logic [5:0] ops [4];
        logic [5:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int sel;
        ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

        bus.start = 1'b0; bus.op = 6'd0; bus.a = 32'd0; bus.b = 32'd0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b0);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_div0",  OP_DIVU, 32'd5, 32'd0, 1'b0);
        run_op("rem_div0",   OP_REM,  32'hFFFF_FFF0, 32'd0, 1'b0);

        // Invalid op code is ignored
        bus.start = 1'b1; bus.op = 6'b000001; bus.a = 32'd5; bus.b = 32'd1;
        #1;
        chk("badop stall", 32'(bus.stall), 32'd0);
        activity = 0;
        repeat (5) begin
            tick();
            if (bus.busy || bus.done) activity++;
        end
        chk("badop activity", 32'(activity), 32'd0);
        bus.start = 1'b0;

        // flush together with start in IDLE drops the start
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd5; bus.flush = 1'b1;
        tick();
        chk("flush_start busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0; bus.flush = 1'b0;

        // flush in the 10th RUN cycle
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("flush pre busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        chk("flush done", 32'(bus.done), 32'd0);
        chk("flush result", bus.result, last_res);
        dones = 0;
        repeat (40) begin
            tick();
            if (bus.done) dones++;
        end
        chk("flush no_done", 32'(dones), 32'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 1'b0);

        // start held during RUN and DONE is ignored
        run_op("hold_start", OP_DIV, 32'd12345, 32'hFFFF_FFF9, 1'b1);

        // reset in the middle of an operation
        bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1234; bus.b = 32'hFFFF_FFFB;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst result", bus.result, 32'd0);
        dones = 0;
        repeat (40) begin
            tick();
            if (bus.done) dones++;
        end
        chk("midrst no_done", 32'(dones), 32'd0);

        // Random operations including corner divisors/dividends
        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 3)];
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 16));
                3:       begin rb = $urandom; ra = 32'h8000_0000; end
                default: rb = $urandom;
            endcase
            run_op("random", rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule
